// File: rtl/femto_bus_pkg.sv
// rtl/femto_bus_pkg.sv - shared constants, FSM encoding and byte-merge helper for the FemtoRV32 bus responder
package femto_bus_pkg;

    localparam logic [2:0]  IO_LEDS     = 3'd0;
    localparam logic [2:0]  IO_TIMER    = 3'd1;
    localparam logic [2:0]  IO_SCRATCH  = 3'd2;

    localparam logic [31:0] BUSERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } respState_t;

    // Replace the bytes of oldWord selected by mask with the matching bytes of newWord.
    function automatic logic [31:0] applyMask(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  mask);
        logic [31:0] merged;
        merged = oldWord;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = newWord[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/femto_bram.sv
// rtl/femto_bram.sv - single-port word RAM with byte enables and one-cycle synchronous read
module femto_bram #(
    parameter int WORDS = 4096,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Byte-lane writes and a registered read of the addressed word every cycle.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/femto_mem_responder.sv
// rtl/femto_mem_responder.sv - FemtoRV32 native-bus RAM/IO responder; FEMTO_RESP_BUSERR_EN enables bus error reporting
module femto_mem_responder #(
    parameter int MEM_WORDS     = 4096,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1,
    parameter int IO_BIT        = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic [7:0]  io_leds,
    output logic        bus_err
);

    import femto_bus_pkg::*;

    localparam int AW = $clog2(MEM_WORDS);

    respState_t    state;
    logic [3:0]    count;
    logic          pendRead;
    logic          ioQ;
    logic          errQ;
    logic [2:0]    ioIdxQ;
    logic [AW-1:0] ramIdxQ;

    logic          isIo;
    logic [2:0]    ioIdx;
    logic [AW-1:0] ramIdx;
    logic          wrReq;
    logic          idle;
    logic          addrErr;
    logic          wrErr;
    logic          busyErr;
    logic          wrCommit;

    logic [31:0]   timer;
    logic [31:0]   scratch;
    logic [31:0]   ioValue;
    logic [31:0]   readValue;
    logic [31:0]   bramDout;
    logic [AW-1:0] bramAddr;
    logic [3:0]    bramWe;
    logic          unusedAddr;

    assign isIo       = mem_addr[IO_BIT];
    assign ioIdx      = mem_addr[4:2];
    assign ramIdx     = mem_addr[AW+1:2];
    assign wrReq      = |mem_wmask;
    assign idle       = (state == ST_IDLE);
    assign unusedAddr = ^mem_addr;

`ifdef FEMTO_RESP_BUSERR_EN
    logic ramOutOfRange;
    logic ioUnmapped;
    assign ramOutOfRange = 32'(mem_addr[IO_BIT-1:2]) >= 32'(MEM_WORDS);
    assign ioUnmapped    = ioIdx > IO_SCRATCH;
    assign addrErr       = isIo ? ioUnmapped : ramOutOfRange;
    assign wrErr         = addrErr | (isIo & (ioIdx == IO_TIMER));
    assign busyErr       = !idle && (wrReq || mem_rstrb);

    // Sticky error flag: any erroneous request sets it until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_err <= 1'b0;
        end else if ((idle && wrReq && wrErr) || (idle && !wrReq && mem_rstrb && addrErr) || busyErr) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign addrErr = 1'b0;
    assign wrErr   = 1'b0;
    assign busyErr = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign wrCommit = idle && wrReq && !wrErr;
    assign bramWe   = (wrCommit && !isIo) ? mem_wmask : 4'h0;
    assign bramAddr = idle ? ramIdx : ramIdxQ;

    femto_bram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) ram (
        .clk   (clk),
        .addr  (bramAddr),
        .we    (bramWe),
        .wdata (mem_wdata),
        .rdata (bramDout)
    );

    // Free-running cycle counter exposed as the TIMER register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer <= 32'h0;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // IO register writes; TIMER and unmapped indices have no write path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            io_leds <= 8'h0;
            scratch <= 32'h0;
        end else if (wrCommit && isIo) begin
            if (ioIdx == IO_LEDS && mem_wmask[0]) begin
                io_leds <= mem_wdata[7:0];
            end
            if (ioIdx == IO_SCRATCH) begin
                scratch <= applyMask(scratch, mem_wdata, mem_wmask);
            end
        end
    end

    // Select the word returned by the read that completes at this edge.
    always_comb begin
        ioValue   = 32'h0;
        readValue = bramDout;
        case (ioIdxQ)
            IO_LEDS:    ioValue = {24'h0, io_leds};
            IO_TIMER:   ioValue = timer;
            IO_SCRATCH: ioValue = scratch;
            default:    ioValue = 32'h0;
        endcase
        if (errQ) begin
            readValue = BUSERR_DATA;
        end else if (ioQ) begin
            readValue = ioValue;
        end
    end

    // Request FSM: accepts in IDLE, counts down wait states, loads mem_rdata on read completion.
    // With a single-cycle read latency the RAM word is only ready one edge later, so the
    // load is deferred through pendRead while the FSM stays in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= 4'h0;
            pendRead  <= 1'b0;
            ioQ       <= 1'b0;
            errQ      <= 1'b0;
            ioIdxQ    <= 3'h0;
            ramIdxQ   <= '0;
            mem_rdata <= 32'h0;
            mem_rbusy <= 1'b0;
            mem_wbusy <= 1'b0;
        end else begin
            pendRead <= 1'b0;
            if (pendRead) begin
                mem_rdata <= readValue;
            end
            case (state)
                ST_IDLE: begin
                    if (wrReq) begin
                        if (WRITE_LATENCY != 0) begin
                            state     <= ST_WR_WAIT;
                            count     <= 4'(WRITE_LATENCY);
                            mem_wbusy <= 1'b1;
                        end
                    end else if (mem_rstrb) begin
                        ioQ     <= isIo;
                        ioIdxQ  <= ioIdx;
                        ramIdxQ <= ramIdx;
                        errQ    <= addrErr;
                        if (READ_LATENCY > 1) begin
                            state     <= ST_RD_WAIT;
                            count     <= 4'(READ_LATENCY - 1);
                            mem_rbusy <= 1'b1;
                        end else begin
                            pendRead <= 1'b1;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (count == 4'd1) begin
                        state     <= ST_IDLE;
                        mem_rbusy <= 1'b0;
                        mem_rdata <= readValue;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_WR_WAIT: begin
                    if (count == 4'd1) begin
                        state     <= ST_IDLE;
                        mem_wbusy <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_rbusy <= 1'b0;
                    mem_wbusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_femto_mem_responder.sv
// tb/tb_femto_mem_responder.sv - self-checking bench for femto_mem_responder
module tb_femto_mem_responder;

    localparam int          MEM_WORDS     = 4096;
    localparam int          READ_LATENCY  = 2;
    localparam int          WRITE_LATENCY = 1;
    localparam int          IO_BIT        = 22;
    localparam logic [31:0] IO_BASE       = 32'h0040_0000;
    localparam int          BOUND         = 40;

`ifdef FEMTO_RESP_BUSERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic [31:0] mem_addr  = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wmask = 4'h0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic [7:0]  io_leds;
    logic        bus_err;

    int checkCount    = 0;
    int passCount     = 0;
    int edgeCount     = 0;
    int lastResetEdge = 0;

    logic [31:0] refRam [int];
    logic [7:0]  refLeds    = 8'h0;
    logic [31:0] refScratch = 32'h0;

    femto_mem_responder #(
        .MEM_WORDS     (MEM_WORDS),
        .READ_LATENCY  (READ_LATENCY),
        .WRITE_LATENCY (WRITE_LATENCY),
        .IO_BIT        (IO_BIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .mem_rbusy (mem_rbusy),
        .mem_wbusy (mem_wbusy),
        .io_leds   (io_leds),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edgeCount = edgeCount + 1;
        if (reset == 1'b0) lastResetEdge = edgeCount;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ramIndex(input logic [31:0] a);
        return int'((a % IO_BASE) / 4) % MEM_WORDS;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] bm;
        bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (o & ~bm) | (n & bm);
    endfunction

    function automatic void modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int idx;
        if (a[IO_BIT]) begin
            if (a[4:2] == 3'd0 && m[0]) refLeds = d[7:0];
            if (a[4:2] == 3'd2) refScratch = merge(refScratch, d, m);
        end else begin
            idx = ramIndex(a);
            refRam[idx] = merge(refRam.exists(idx) ? refRam[idx] : 32'h0, d, m);
        end
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a, input int loadEdge);
        int idx;
        if (a[IO_BIT]) begin
            case (a[4:2])
                3'd0:    return {24'h0, refLeds};
                3'd1:    return 32'(loadEdge - lastResetEdge - 1);
                3'd2:    return refScratch;
                default: return ERR_EN ? 32'hDEADBEEF : 32'h0;
            endcase
        end
        idx = ramIndex(a);
        return refRam.exists(idx) ? refRam[idx] : 32'h0;
    endfunction

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, output int busy);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        tick();
        mem_wmask = 4'h0;
        modelWrite(a, d, m);
        busy = 0;
        while (mem_wbusy === 1'b1 && busy < BOUND) begin
            busy++;
            tick();
        end
    endtask

    task automatic doRead(input logic [31:0] a, output logic [31:0] data, output int busy, output int loadEdge);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        tick();
        mem_rstrb = 1'b0;
        busy = 0;
        while (mem_rbusy === 1'b1 && busy < BOUND) begin
            busy++;
            tick();
        end
        data     = mem_rdata;
        loadEdge = edgeCount;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checkCount++; if (mem_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected %h", mem_rdata, 32'h0); else passCount++;
        checkCount++; if (mem_rbusy !== 1'b0) $display("FAIL reset_rbusy: got %b expected 0", mem_rbusy); else passCount++;
        checkCount++; if (mem_wbusy !== 1'b0) $display("FAIL reset_wbusy: got %b expected 0", mem_wbusy); else passCount++;
        checkCount++; if (io_leds !== 8'h0) $display("FAIL reset_leds: got %h expected 00", io_leds); else passCount++;
        checkCount++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b expected 0", bus_err); else passCount++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_default_latency();
        logic [31:0] d;
        int wb, rb, le;
        doWrite(32'h100, 32'h12345678, 4'b1111, wb);
        checkCount++; if (wb !== WRITE_LATENCY) $display("FAIL full_write_wbusy: got %0d cycles expected %0d", wb, WRITE_LATENCY); else passCount++;
        doRead(32'h100, d, rb, le);
        checkCount++; if (rb !== READ_LATENCY - 1) $display("FAIL read_rbusy: got %0d cycles expected %0d", rb, READ_LATENCY - 1); else passCount++;
        checkCount++; if (d !== 32'h12345678) $display("FAIL read_0x100: got %h expected %h", d, 32'h12345678); else passCount++;
    endtask

    task automatic test_byte_write();
        logic [31:0] d;
        int wb, rb, le;
        doWrite(32'h100, 32'hAB000000, 4'b1000, wb);
        checkCount++; if (wb !== WRITE_LATENCY) $display("FAIL byte_write_wbusy: got %0d cycles expected %0d", wb, WRITE_LATENCY); else passCount++;
        doRead(32'h100, d, rb, le);
        checkCount++; if (d !== 32'hAB345678) $display("FAIL byte_write_read: got %h expected %h", d, 32'hAB345678); else passCount++;
    endtask

    task automatic test_io();
        logic [31:0] d, t1, t2, sv;
        int wb, rb, e1, e2;
        doWrite(IO_BASE, 32'h0000005A, 4'b1111, wb);
        checkCount++; if (io_leds !== 8'h5A) $display("FAIL leds_write: got %h expected %h", io_leds, 8'h5A); else passCount++;
        doRead(IO_BASE, d, rb, e1);
        checkCount++; if (d !== 32'h5A) $display("FAIL leds_read: got %h expected %h", d, 32'h5A); else passCount++;
        sv = $urandom;
        doWrite(IO_BASE + 32'h8, sv, 4'b0101, wb);
        doRead(IO_BASE + 32'h8, d, rb, e1);
        checkCount++; if (d !== modelRead(IO_BASE + 32'h8, e1)) $display("FAIL scratch_read: got %h expected %h", d, modelRead(IO_BASE + 32'h8, e1)); else passCount++;
        doRead(IO_BASE + 32'h4, t1, rb, e1);
        doRead(IO_BASE + 32'h4, t2, rb, e2);
        checkCount++; if (t1 !== modelRead(IO_BASE + 32'h4, e1)) $display("FAIL timer_read: got %h expected %h", t1, modelRead(IO_BASE + 32'h4, e1)); else passCount++;
        checkCount++; if (t2 - t1 !== 32'(e2 - e1)) $display("FAIL timer_delta: got %0d expected %0d", t2 - t1, e2 - e1); else passCount++;
    endtask

    task automatic test_simultaneous();
        logic [31:0] prev, d;
        int rb, le;
        doRead(32'h100, prev, rb, le);
        mem_addr  = 32'h200;
        mem_wdata = 32'hCAFEF00D;
        mem_wmask = 4'b1111;
        mem_rstrb = 1'b1;
        tick();
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        modelWrite(32'h200, 32'hCAFEF00D, 4'b1111);
        checkCount++; if (mem_rbusy !== 1'b0) $display("FAIL simul_rbusy: got %b expected 0", mem_rbusy); else passCount++;
        checkCount++; if (mem_wbusy !== 1'b1) $display("FAIL simul_wbusy: got %b expected 1", mem_wbusy); else passCount++;
        tick();
        tick();
        checkCount++; if (mem_rdata !== prev) $display("FAIL simul_rdata_held: got %h expected %h", mem_rdata, prev); else passCount++;
        doRead(32'h200, d, rb, le);
        checkCount++; if (d !== 32'hCAFEF00D) $display("FAIL simul_ram: got %h expected %h", d, 32'hCAFEF00D); else passCount++;
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp;
        int wb, rb, le, op;
        for (int w = 0; w < 8; w++) doWrite(32'h300 + 32'(4 * w), $urandom, 4'b1111, wb);
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: doWrite(32'h300 + 32'(4 * $urandom_range(0, 7)), $urandom, 4'($urandom_range(1, 15)), wb);
                1: begin
                    a = 32'h300 + 32'(4 * $urandom_range(0, 7));
                    doRead(a, d, rb, le);
                    exp = modelRead(a, le);
                    checkCount++; if (d !== exp || rb !== READ_LATENCY - 1) $display("FAIL rand_ram_read: got %h/%0d expected %h/%0d", d, rb, exp, READ_LATENCY - 1); else passCount++;
                end
                2: doWrite(IO_BASE + (($urandom_range(0, 1) == 0) ? 32'h0 : 32'h8), $urandom, 4'($urandom_range(1, 15)), wb);
                3: begin
                    a = IO_BASE + 32'(4 * $urandom_range(0, 2));
                    doRead(a, d, rb, le);
                    exp = modelRead(a, le);
                    checkCount++; if (d !== exp) $display("FAIL rand_io_read: got %h expected %h", d, exp); else passCount++;
                    checkCount++; if (io_leds !== refLeds) $display("FAIL rand_leds: got %h expected %h", io_leds, refLeds); else passCount++;
                end
                default: repeat ($urandom_range(0, 3)) tick();
            endcase
        end
    endtask

    task automatic test_bus_error();
        logic [31:0] d;
        int rb, le, wb;
        doRead(IO_BASE + 32'h1C, d, rb, le);
        checkCount++; if (d !== (ERR_EN ? 32'hDEADBEEF : 32'h0)) $display("FAIL unmapped_read: got %h expected %h", d, ERR_EN ? 32'hDEADBEEF : 32'h0); else passCount++;
        checkCount++; if (bus_err !== ERR_EN) $display("FAIL unmapped_bus_err: got %b expected %b", bus_err, ERR_EN); else passCount++;
        doRead(32'h100, d, rb, le);
        checkCount++; if (d !== modelRead(32'h100, le)) $display("FAIL after_err_read: got %h expected %h", d, modelRead(32'h100, le)); else passCount++;
        checkCount++; if (bus_err !== ERR_EN) $display("FAIL bus_err_held: got %b expected %b", bus_err, ERR_EN); else passCount++;
`ifndef FEMTO_RESP_BUSERR_EN
        doWrite(32'h100 + 32'(MEM_WORDS * 4), 32'h0BADCAFE, 4'b1111, wb);
        doRead(32'h100, d, rb, le);
        checkCount++; if (d !== 32'h0BADCAFE) $display("FAIL ram_wrap: got %h expected %h", d, 32'h0BADCAFE); else passCount++;
        mem_addr  = IO_BASE + 32'h4;
        mem_wdata = 32'hFFFF0000;
        mem_wmask = 4'b1111;
        tick();
        mem_wmask = 4'h0;
        tick();
        doRead(IO_BASE + 32'h4, d, rb, le);
        checkCount++; if (d !== modelRead(IO_BASE + 32'h4, le)) $display("FAIL timer_write_dropped: got %h expected %h", d, modelRead(IO_BASE + 32'h4, le)); else passCount++;
`endif
    endtask

    task automatic test_busy_ignore();
        logic [31:0] d;
        int wb, rb, le;
        doWrite(32'h104, 32'h11112222, 4'b1111, wb);
        doWrite(32'h120, 32'h33334444, 4'b1111, wb);
        mem_addr  = 32'h104;
        mem_rstrb = 1'b1;
        tick();
        mem_rstrb = 1'b0;
        mem_addr  = 32'h120;
        mem_wdata = 32'h55556666;
        mem_wmask = 4'b1111;
        tick();
        mem_wmask = 4'h0;
        checkCount++; if (mem_rdata !== 32'h11112222) $display("FAIL busy_read_data: got %h expected %h", mem_rdata, 32'h11112222); else passCount++;
        checkCount++; if (mem_wbusy !== 1'b0) $display("FAIL busy_write_wbusy: got %b expected 0", mem_wbusy); else passCount++;
        doRead(32'h120, d, rb, le);
        checkCount++; if (d !== 32'h33334444) $display("FAIL write_in_rd_wait: got %h expected %h", d, 32'h33334444); else passCount++;
        mem_addr  = 32'h120;
        mem_wdata = 32'h77778888;
        mem_wmask = 4'b1111;
        tick();
        modelWrite(32'h120, 32'h77778888, 4'b1111);
        mem_wdata = 32'h9999AAAA;
        tick();
        mem_wmask = 4'h0;
        doRead(32'h120, d, rb, le);
        checkCount++; if (d !== 32'h77778888) $display("FAIL write_in_wr_wait: got %h expected %h", d, 32'h77778888); else passCount++;
        checkCount++; if (bus_err !== ERR_EN) $display("FAIL busy_bus_err: got %b expected %b", bus_err, ERR_EN); else passCount++;
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        int wb, rb, le;
        doWrite(32'h140, 32'hFEEDBEEF, 4'b1111, wb);
        doWrite(IO_BASE, 32'h33, 4'b0001, wb);
        doWrite(IO_BASE + 32'h8, 32'h01020304, 4'b1111, wb);
        mem_addr  = 32'h140;
        mem_rstrb = 1'b1;
        tick();
        mem_rstrb = 1'b0;
        checkCount++; if (mem_rbusy !== 1'b1) $display("FAIL mid_rd_wait: got %b expected 1", mem_rbusy); else passCount++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        refLeds    = 8'h0;
        refScratch = 32'h0;
        checkCount++; if (mem_rbusy !== 1'b0) $display("FAIL mid_reset_rbusy: got %b expected 0", mem_rbusy); else passCount++;
        checkCount++; if (mem_rdata !== 32'h0) $display("FAIL mid_reset_rdata: got %h expected %h", mem_rdata, 32'h0); else passCount++;
        checkCount++; if (io_leds !== 8'h0) $display("FAIL mid_reset_leds: got %h expected 00", io_leds); else passCount++;
        checkCount++; if (bus_err !== 1'b0) $display("FAIL mid_reset_bus_err: got %b expected 0", bus_err); else passCount++;
        tick();
        doRead(32'h140, d, rb, le);
        checkCount++; if (d !== 32'hFEEDBEEF) $display("FAIL ram_survives_reset: got %h expected %h", d, 32'hFEEDBEEF); else passCount++;
        doRead(IO_BASE + 32'h8, d, rb, le);
        checkCount++; if (d !== 32'h0) $display("FAIL scratch_after_reset: got %h expected %h", d, 32'h0); else passCount++;
        doRead(IO_BASE + 32'h4, d, rb, le);
        checkCount++; if (d !== modelRead(IO_BASE + 32'h4, le)) $display("FAIL timer_after_reset: got %h expected %h", d, modelRead(IO_BASE + 32'h4, le)); else passCount++;
    endtask

    initial begin
        test_reset();
        test_default_latency();
        test_byte_write();
        test_io();
        test_simultaneous();
        test_random();
        test_bus_error();
        test_busy_ignore();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
